// File: rtl/snake_pkg.sv
// Shared types and timing defaults for the snake game blocks.
// Defaults assume the 100 MHz system clock.
`timescale 1ns/1ps
package snake_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EAT   = 2'd1,
        CRASH = 2'd2
    } state_e;

    localparam int unsigned CLK_HZ = 100_000_000;

    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    localparam int unsigned EAT_CYCLES_DEF   = ms_to_cycles(200);
    localparam int unsigned CRASH_CYCLES_DEF = ms_to_cycles(800);
    localparam int unsigned DEB_CYCLES_DEF   = ms_to_cycles(10);
    localparam int unsigned CNT_W_DEF        = 27;

endpackage

// File: rtl/btn_debounce.sv
// Synchronises and debounces a raw push button, producing a clean level
// and a one-cycle pulse on each debounced rising edge.
`timescale 1ns/1ps
module btn_debounce
    import snake_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic rise_pulse_o
);

    localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] LAST = DW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic [DW-1:0] cnt_q, cnt_d;

    // Run length of disagreement; any sample matching the level restarts it.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        pulse_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == LAST) begin
                level_d = sync2_q;
                pulse_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o      = level_q;
    assign rise_pulse_o = pulse_q;

endmodule

// File: rtl/beep_trigger.sv
// Turns one-cycle eat/crash game events into the active-low hold level for
// the music player, with a debounced mute toggle; crash preempts eat.
`timescale 1ns/1ps
module beep_trigger
    import snake_pkg::*;
#(
    parameter int unsigned EAT_CYCLES   = EAT_CYCLES_DEF,
    parameter int unsigned CRASH_CYCLES = CRASH_CYCLES_DEF,
    parameter int unsigned DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic eat_evt,
    input  logic crash_evt,
    input  logic mute_btn,
    output logic key_n,
    output logic muted,
    output logic busy
);

    localparam logic [CNT_W-1:0] EAT_LOAD   = CNT_W'(EAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CRASH_LOAD = CNT_W'(CRASH_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               key_n_q, key_n_d;
    logic               busy_q, busy_d;
    logic               muted_q, muted_d;
    logic               deb_level, deb_rise;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_mute_deb (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_i       (mute_btn),
        .level_o     (deb_level),
        .rise_pulse_o(deb_rise)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (crash_evt) begin
                    state_d = CRASH;
                    cnt_d   = CRASH_LOAD;
                end else if (eat_evt) begin
                    state_d = EAT;
                    cnt_d   = EAT_LOAD;
                end
            end
            EAT: begin
                if (crash_evt) begin
                    state_d = CRASH;
                    cnt_d   = CRASH_LOAD;
                end else if (eat_evt) begin
                    cnt_d = EAT_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CRASH: begin
                if (crash_evt) begin
                    cnt_d = CRASH_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // The rise pulse is only ever high while the debounced level is high.
        muted_d = muted_q ^ (deb_rise & deb_level);
        busy_d  = (state_d != IDLE);
        key_n_d = !busy_d || muted_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            key_n_q <= 1'b1;
            busy_q  <= 1'b0;
            muted_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_n_q <= key_n_d;
            busy_q  <= busy_d;
            muted_q <= muted_d;
        end
    end

    assign key_n = key_n_q;
    assign busy  = busy_q;
    assign muted = muted_q;

endmodule

// File: tb/tb_beep_trigger.sv
// Self-checking bench for beep_trigger with short hold and debounce times.
`timescale 1ns/1ps
module tb_beep_trigger;

    localparam int EATC   = 20;
    localparam int CRASHC = 50;
    localparam int DEBC   = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic eat_evt = 1'b0;
    logic crash_evt = 1'b0;
    logic mute_btn = 1'b0;
    logic key_n, muted, busy;

    always #5 clk = ~clk;

    beep_trigger #(
        .EAT_CYCLES  (EATC),
        .CRASH_CYCLES(CRASHC),
        .DEB_CYCLES  (DEBC),
        .CNT_W       (27)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .eat_evt  (eat_evt),
        .crash_evt(crash_evt),
        .mute_btn (mute_btn),
        .key_n    (key_n),
        .muted    (muted),
        .busy     (busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining low cycles of the current hold, and the
    // mute toggle derived from the button delayed by two sampling edges.
    int m_rem = 0;
    bit m_crash = 0;
    bit m_muted = 0, m_lvl = 0, m_pend = 0;
    int m_run = 0;
    bit h1 = 0, h2 = 0, seen = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem = 0; m_crash = 0;
            m_muted = 0; m_lvl = 0; m_pend = 0; m_run = 0;
            h1 = 0; h2 = 0;
        end else begin
            seen = h2;
            h2 = h1;
            h1 = mute_btn;
            if (m_pend) m_muted = !m_muted;
            m_pend = 0;
            if (seen != m_lvl) begin
                m_run++;
                if (m_run == DEBC) begin
                    m_lvl = seen;
                    m_run = 0;
                    if (seen) m_pend = 1;
                end
            end else begin
                m_run = 0;
            end
            if (crash_evt) begin
                m_rem = CRASHC; m_crash = 1;
            end else if (eat_evt && !(m_crash && m_rem > 0)) begin
                m_rem = EATC; m_crash = 0;
            end else if (m_rem > 0) begin
                m_rem--;
            end
        end
    end

    int  low_cnt = 0, busy_cnt = 0, mute_rises = 0, key_rises = 0;
    logic prev_muted = 1'b0, prev_key = 1'b1;

    always @(negedge clk) begin
        if (rst_n) begin
            check("key_n_model", key_n, (m_rem == 0) || m_muted);
            check("busy_model", busy, m_rem > 0);
            check("muted_model", muted, m_muted);
            if (key_n === 1'b0) low_cnt++;
            if (busy === 1'b1) busy_cnt++;
            if (muted === 1'b1 && prev_muted === 1'b0) mute_rises++;
            if (key_n === 1'b1 && prev_key === 1'b0) key_rises++;
        end
        prev_muted = muted;
        prev_key = key_n;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic clr();
        low_cnt = 0; busy_cnt = 0; mute_rises = 0; key_rises = 0;
    endtask

    task automatic pulse_eat();
        eat_evt = 1'b1; tick(); eat_evt = 1'b0;
    endtask

    task automatic pulse_crash();
        crash_evt = 1'b1; tick(); crash_evt = 1'b0;
    endtask

    initial begin
        idle(3);
        rst_n = 1'b1;
        tick();
        check("rst_key_n", key_n, 1);
        check("rst_busy", busy, 0);
        check("rst_muted", muted, 0);

        // Single eat hold
        clr(); pulse_eat(); idle(40);
        check("eat_low_cycles", low_cnt, EATC);
        check("eat_busy_cycles", busy_cnt, EATC);

        // Crash preempts eat five cycles in, no gap in the low level
        clr(); pulse_eat(); idle(4); pulse_crash(); idle(80);
        check("preempt_low_cycles", low_cnt, 5 + CRASHC);
        check("preempt_busy_cycles", busy_cnt, 5 + CRASHC);
        check("preempt_key_rises", key_rises, 1);

        // Simultaneous events, then an eat during the crash hold
        clr(); eat_evt = 1'b1; crash_evt = 1'b1; tick(); eat_evt = 1'b0; crash_evt = 1'b0;
        idle(9); pulse_eat(); idle(70);
        check("both_low_cycles", low_cnt, CRASHC);
        check("both_busy_cycles", busy_cnt, CRASHC);

        // Bouncy mute press, then stable
        clr();
        for (int i = 0; i < 10; i++) begin
            mute_btn = (i % 2 == 0);
            idle(3);
        end
        mute_btn = 1'b1;
        idle(10);
        check("mute_not_yet", muted, 0);
        idle(1);
        check("mute_on_time", muted, 1);
        idle(5);
        check("mute_single_toggle", mute_rises, 1);
        clr(); pulse_eat(); idle(30);
        check("muted_eat_low", low_cnt, 0);
        check("muted_eat_busy", busy_cnt, EATC);

        // Unmute, then mute and unmute again inside a crash hold
        mute_btn = 1'b0; idle(15);
        mute_btn = 1'b1; idle(15);
        mute_btn = 1'b0; idle(15);
        check("unmuted_before_crash", muted, 0);
        clr(); pulse_crash(); idle(2);
        mute_btn = 1'b1; idle(11);
        check("muted_in_crash", muted, 1);
        mute_btn = 1'b0; idle(10);
        mute_btn = 1'b1; idle(40);
        check("mute_crash_low", low_cnt, 29);
        check("mute_crash_busy", busy_cnt, CRASHC);
        mute_btn = 1'b0; idle(15);

        // Asynchronous reset in the middle of a crash hold
        clr(); pulse_crash(); idle(20);
        check("pre_rst_key_n", key_n, 0);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_key_n", key_n, 1);
        check("async_rst_busy", busy, 0);
        idle(2);
        rst_n = 1'b1;
        clr(); idle(30);
        check("post_rst_low", low_cnt, 0);
        check("post_rst_busy", busy_cnt, 0);

        // Reset clears mute
        mute_btn = 1'b1; idle(15);
        mute_btn = 1'b0; idle(15);
        check("muted_before_rst", muted, 1);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_muted", muted, 0);
        idle(2);
        rst_n = 1'b1;
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
